// File: rtl/dma_dsc_cache_ctrl.sv
// Descriptor cache front-end: tracks per-entry valid bits, drives the 2-stage registered-read
// cache RAM and returns descriptors (or an empty-entry error) over a valid/ready response port.
module dma_dsc_cache_ctrl #(
  parameter int unsigned WIDTH     = 128,
  parameter int unsigned DEPTH     = 128,
  parameter int unsigned ADDR_W    = 7,
  parameter bit          CLR_ON_RD = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              dsc_wr_valid,
  output logic              dsc_wr_ready,
  input  logic [ADDR_W-1:0] dsc_wr_idx,
  input  logic [WIDTH-1:0]  dsc_wr_data,
  input  logic              dsc_inv,
  input  logic [ADDR_W-1:0] dsc_inv_idx,
  input  logic              dsc_rd_req_valid,
  output logic              dsc_rd_req_ready,
  input  logic [ADDR_W-1:0] dsc_rd_req_idx,
  output logic              dsc_rd_valid,
  input  logic              dsc_rd_ready,
  output logic [WIDTH-1:0]  dsc_rd_data,
  output logic              dsc_rd_err,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [WIDTH-1:0]  ram_wdata,
  output logic              ram_ren,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [WIDTH-1:0]  ram_rdata,
  output logic [ADDR_W:0]   valid_cnt
);

  typedef enum logic [1:0] {StIdle, StWait, StCapt, StHold} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   rd_idx_q;
  logic [WIDTH-1:0]    rd_data_q;
  logic                rd_err_q;
  logic                rd_valid_q;
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [1:0]          n_set, n_clr;

  logic wr_fire, req_fire, hit, rd_clr;

  // Block writes to the entry whose RAM read is still in flight.
  assign dsc_wr_ready = !(((state_q == StWait) || (state_q == StCapt)) &&
                          (dsc_wr_idx == rd_idx_q));
  assign wr_fire      = dsc_wr_valid & dsc_wr_ready;

  assign dsc_rd_req_ready = (state_q == StIdle);
  assign req_fire         = dsc_rd_req_valid & dsc_rd_req_ready;
  assign hit              = valid_q[dsc_rd_req_idx];
  assign rd_clr           = CLR_ON_RD && req_fire && hit;

  assign ram_wen   = wr_fire;
  assign ram_waddr = dsc_wr_idx;
  assign ram_wdata = dsc_wr_data;
  assign ram_ren   = req_fire & hit;
  assign ram_raddr = dsc_rd_req_idx;

  assign dsc_rd_valid = rd_valid_q;
  assign dsc_rd_data  = rd_data_q;
  assign dsc_rd_err   = rd_err_q;
  assign valid_cnt    = cnt_q;

  // Later assignments win: write set beats invalidate beats read clear.
  always_comb begin
    valid_d = valid_q;
    if (rd_clr) valid_d[dsc_rd_req_idx] = 1'b0;
    if (dsc_inv) valid_d[dsc_inv_idx] = 1'b0;
    if (wr_fire) valid_d[dsc_wr_idx] = 1'b1;
  end

  // Only the (up to three) touched indices can change; count each distinct one once.
  always_comb begin
    n_set = 2'd0;
    n_clr = 2'd0;
    if (valid_d[dsc_wr_idx] && !valid_q[dsc_wr_idx]) n_set = n_set + 2'd1;
    if (!valid_d[dsc_wr_idx] && valid_q[dsc_wr_idx]) n_clr = n_clr + 2'd1;
    if (dsc_inv_idx != dsc_wr_idx) begin
      if (valid_d[dsc_inv_idx] && !valid_q[dsc_inv_idx]) n_set = n_set + 2'd1;
      if (!valid_d[dsc_inv_idx] && valid_q[dsc_inv_idx]) n_clr = n_clr + 2'd1;
    end
    if ((dsc_rd_req_idx != dsc_wr_idx) && (dsc_rd_req_idx != dsc_inv_idx)) begin
      if (valid_d[dsc_rd_req_idx] && !valid_q[dsc_rd_req_idx]) n_set = n_set + 2'd1;
      if (!valid_d[dsc_rd_req_idx] && valid_q[dsc_rd_req_idx]) n_clr = n_clr + 2'd1;
    end
    cnt_d = cnt_q + {{(ADDR_W - 1){1'b0}}, n_set} - {{(ADDR_W - 1){1'b0}}, n_clr};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      rd_idx_q   <= '0;
      rd_data_q  <= '0;
      rd_err_q   <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_fire) begin
            rd_idx_q <= dsc_rd_req_idx;
            if (hit) begin
              state_q <= StWait;
            end else begin
              state_q    <= StHold;
              rd_data_q  <= '0;
              rd_err_q   <= 1'b1;
              rd_valid_q <= 1'b1;
            end
          end
        end
        StWait: state_q <= StCapt;
        StCapt: begin
          state_q    <= StHold;
          rd_data_q  <= ram_rdata;
          rd_err_q   <= 1'b0;
          rd_valid_q <= 1'b1;
        end
        StHold: begin
          if (dsc_rd_ready) begin
            state_q    <= StIdle;
            rd_err_q   <= 1'b0;
            rd_valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_dsc_cache_ctrl.sv
// Directed bench for dma_dsc_cache_ctrl with a 2-stage registered-read RAM model.
module tb_dma_dsc_cache_ctrl;

  localparam int unsigned WIDTH  = 128;
  localparam int unsigned DEPTH  = 128;
  localparam int unsigned ADDR_W = 7;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              dsc_wr_valid, dsc_wr_ready;
  logic [ADDR_W-1:0] dsc_wr_idx;
  logic [WIDTH-1:0]  dsc_wr_data;
  logic              dsc_inv;
  logic [ADDR_W-1:0] dsc_inv_idx;
  logic              dsc_rd_req_valid, dsc_rd_req_ready;
  logic [ADDR_W-1:0] dsc_rd_req_idx;
  logic              dsc_rd_valid, dsc_rd_ready;
  logic [WIDTH-1:0]  dsc_rd_data;
  logic              dsc_rd_err;
  logic              ram_wen, ram_ren;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  logic [WIDTH-1:0]  ram_wdata, ram_rdata;
  logic [ADDR_W:0]   valid_cnt;

  int checks = 0;
  int errors = 0;
  int ren_cnt = 0;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] ram_s1;

  localparam logic [WIDTH-1:0] PAT_A5 = {16{8'hA5}};
  localparam logic [WIDTH-1:0] PAT_P  = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [WIDTH-1:0] PAT_Q  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [WIDTH-1:0] PAT_R  = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
  localparam logic [WIDTH-1:0] PAT_N  = 128'hDEADBEEF_CAFEF00D_0BADC0DE_FEEDFACE;

  always #5 clock = ~clock;

  dma_dsc_cache_ctrl #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .CLR_ON_RD(1'b1)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .dsc_wr_valid    (dsc_wr_valid),
    .dsc_wr_ready    (dsc_wr_ready),
    .dsc_wr_idx      (dsc_wr_idx),
    .dsc_wr_data     (dsc_wr_data),
    .dsc_inv         (dsc_inv),
    .dsc_inv_idx     (dsc_inv_idx),
    .dsc_rd_req_valid(dsc_rd_req_valid),
    .dsc_rd_req_ready(dsc_rd_req_ready),
    .dsc_rd_req_idx  (dsc_rd_req_idx),
    .dsc_rd_valid    (dsc_rd_valid),
    .dsc_rd_ready    (dsc_rd_ready),
    .dsc_rd_data     (dsc_rd_data),
    .dsc_rd_err      (dsc_rd_err),
    .ram_wen         (ram_wen),
    .ram_waddr       (ram_waddr),
    .ram_wdata       (ram_wdata),
    .ram_ren         (ram_ren),
    .ram_raddr       (ram_raddr),
    .ram_rdata       (ram_rdata),
    .valid_cnt       (valid_cnt)
  );

  // Registered-read RAM: address sampled on the enable edge, data one edge later.
  always @(posedge clock) begin
    if (ram_wen) mem[ram_waddr] <= ram_wdata;
    if (ram_ren) begin
      ram_s1  <= mem[ram_raddr];
      ren_cnt <= ren_cnt + 1;
    end
    ram_rdata <= ram_s1;
  end

  task automatic test_reset;
    @(negedge clock);
    checks++; if (dsc_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", dsc_rd_valid); end
    checks++; if (dsc_rd_err !== 1'b0) begin errors++; $display("FAIL reset_rd_err: got %b expected 0", dsc_rd_err); end
    checks++; if (dsc_rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", dsc_rd_data); end
    checks++; if (valid_cnt !== 8'd0) begin errors++; $display("FAIL reset_valid_cnt: got %0d expected 0", valid_cnt); end
    checks++; if (dsc_rd_req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", dsc_rd_req_ready); end
    reset_n = 1'b1;
  endtask

  task automatic test_write;
    @(negedge clock);
    dsc_wr_valid = 1'b1; dsc_wr_idx = 7'd5; dsc_wr_data = PAT_A5;
    #1;
    checks++; if (ram_wen !== 1'b1) begin errors++; $display("FAIL wr_ram_wen: got %b expected 1", ram_wen); end
    checks++; if (ram_waddr !== 7'd5) begin errors++; $display("FAIL wr_ram_waddr: got %0d expected 5", ram_waddr); end
    checks++; if (ram_wdata !== PAT_A5) begin errors++; $display("FAIL wr_ram_wdata: got %h expected %h", ram_wdata, PAT_A5); end
    @(posedge clock); #1;
    dsc_wr_valid = 1'b0;
    checks++; if (valid_cnt !== 8'd1) begin errors++; $display("FAIL wr_valid_cnt: got %0d expected 1", valid_cnt); end
  endtask

  task automatic test_read_hit;
    @(negedge clock);
    dsc_rd_req_valid = 1'b1; dsc_rd_req_idx = 7'd5; dsc_rd_ready = 1'b1;
    #1;
    checks++; if (ram_ren !== 1'b1) begin errors++; $display("FAIL hit_ram_ren: got %b expected 1", ram_ren); end
    checks++; if (ram_raddr !== 7'd5) begin errors++; $display("FAIL hit_ram_raddr: got %0d expected 5", ram_raddr); end
    @(posedge clock); #1;
    dsc_rd_req_valid = 1'b0;
    checks++; if (ram_ren !== 1'b0) begin errors++; $display("FAIL hit_ren_drop: got %b expected 0", ram_ren); end
    checks++; if (valid_cnt !== 8'd0) begin errors++; $display("FAIL hit_clr_on_rd: got %0d expected 0", valid_cnt); end
    checks++; if (dsc_rd_valid !== 1'b0) begin errors++; $display("FAIL hit_valid_k: got %b expected 0", dsc_rd_valid); end
    @(posedge clock); #1;
    checks++; if (dsc_rd_valid !== 1'b0) begin errors++; $display("FAIL hit_valid_k1: got %b expected 0", dsc_rd_valid); end
    @(posedge clock); #1;
    checks++; if (dsc_rd_valid !== 1'b1) begin errors++; $display("FAIL hit_valid_k2: got %b expected 1", dsc_rd_valid); end
    checks++; if (dsc_rd_data !== PAT_A5) begin errors++; $display("FAIL hit_data: got %h expected %h", dsc_rd_data, PAT_A5); end
    checks++; if (dsc_rd_err !== 1'b0) begin errors++; $display("FAIL hit_err: got %b expected 0", dsc_rd_err); end
    @(posedge clock); #1;
    checks++; if (dsc_rd_valid !== 1'b0) begin errors++; $display("FAIL hit_release: got %b expected 0", dsc_rd_valid); end
    checks++; if (dsc_rd_req_ready !== 1'b1) begin errors++; $display("FAIL hit_req_ready: got %b expected 1", dsc_rd_req_ready); end
    dsc_rd_ready = 1'b0;
  endtask

  task automatic test_read_miss;
    int n0;
    n0 = ren_cnt;
    @(negedge clock);
    dsc_rd_req_valid = 1'b1; dsc_rd_req_idx = 7'd9;
    #1;
    checks++; if (ram_ren !== 1'b0) begin errors++; $display("FAIL miss_ram_ren: got %b expected 0", ram_ren); end
    @(posedge clock); #1;
    dsc_rd_req_valid = 1'b0;
    checks++; if (dsc_rd_valid !== 1'b1) begin errors++; $display("FAIL miss_valid: got %b expected 1", dsc_rd_valid); end
    checks++; if (dsc_rd_err !== 1'b1) begin errors++; $display("FAIL miss_err: got %b expected 1", dsc_rd_err); end
    checks++; if (dsc_rd_data !== '0) begin errors++; $display("FAIL miss_data: got %h expected 0", dsc_rd_data); end
    @(negedge clock); dsc_rd_ready = 1'b1;
    @(posedge clock); #1;
    dsc_rd_ready = 1'b0;
    checks++; if (dsc_rd_valid !== 1'b0) begin errors++; $display("FAIL miss_release: got %b expected 0", dsc_rd_valid); end
    checks++; if (dsc_rd_err !== 1'b0) begin errors++; $display("FAIL miss_err_clr: got %b expected 0", dsc_rd_err); end
    checks++; if (ren_cnt !== n0) begin errors++; $display("FAIL miss_ren_count: got %0d expected %0d", ren_cnt, n0); end
  endtask

  task automatic test_backpressure;
    @(negedge clock);
    dsc_wr_valid = 1'b1; dsc_wr_idx = 7'd10; dsc_wr_data = PAT_P;
    @(negedge clock);
    dsc_wr_valid = 1'b0;
    dsc_rd_req_valid = 1'b1; dsc_rd_req_idx = 7'd10;
    @(posedge clock); #1;
    dsc_rd_req_valid = 1'b0;
    @(posedge clock);
    @(posedge clock); #1;
    checks++; if (dsc_rd_data !== PAT_P) begin errors++; $display("FAIL bp_data: got %h expected %h", dsc_rd_data, PAT_P); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      checks++; if (dsc_rd_valid !== 1'b1 || dsc_rd_err !== 1'b0 || dsc_rd_data !== PAT_P || dsc_rd_req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: got valid=%b err=%b req_ready=%b data=%h expected valid=1 err=0 req_ready=0 data=%h",
                 i, dsc_rd_valid, dsc_rd_err, dsc_rd_req_ready, dsc_rd_data, PAT_P);
      end
    end
    @(negedge clock); dsc_rd_ready = 1'b1;
    @(posedge clock); #1;
    dsc_rd_ready = 1'b0;
    checks++; if (dsc_rd_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %b expected 0", dsc_rd_valid); end
    checks++; if (dsc_rd_data !== PAT_P) begin errors++; $display("FAIL bp_data_retain: got %h expected %h", dsc_rd_data, PAT_P); end
  endtask

  task automatic test_hazard;
    @(negedge clock);
    dsc_wr_valid = 1'b1; dsc_wr_idx = 7'd3; dsc_wr_data = PAT_Q;
    @(negedge clock);
    dsc_wr_valid = 1'b0;
    dsc_rd_req_valid = 1'b1; dsc_rd_req_idx = 7'd3;
    @(posedge clock); #1;
    dsc_rd_req_valid = 1'b0;
    dsc_wr_valid = 1'b1; dsc_wr_idx = 7'd3; dsc_wr_data = PAT_R;
    #1;
    checks++; if (dsc_wr_ready !== 1'b0) begin errors++; $display("FAIL haz_wait_ready: got %b expected 0", dsc_wr_ready); end
    checks++; if (ram_wen !== 1'b0) begin errors++; $display("FAIL haz_wait_wen: got %b expected 0", ram_wen); end
    dsc_wr_idx = 7'd4;
    #1;
    checks++; if (dsc_wr_ready !== 1'b1) begin errors++; $display("FAIL haz_other_ready: got %b expected 1", dsc_wr_ready); end
    @(posedge clock); #1;
    dsc_wr_idx = 7'd3;
    #1;
    checks++; if (dsc_wr_ready !== 1'b0) begin errors++; $display("FAIL haz_capt_ready: got %b expected 0", dsc_wr_ready); end
    @(posedge clock); #1;
    checks++; if (dsc_wr_ready !== 1'b1) begin errors++; $display("FAIL haz_hold_ready: got %b expected 1", dsc_wr_ready); end
    dsc_wr_valid = 1'b0;
    checks++; if (dsc_rd_data !== PAT_Q) begin errors++; $display("FAIL haz_data: got %h expected %h", dsc_rd_data, PAT_Q); end
    checks++; if (valid_cnt !== 8'd1) begin errors++; $display("FAIL haz_valid_cnt: got %0d expected 1", valid_cnt); end
    @(negedge clock); dsc_rd_ready = 1'b1;
    @(posedge clock); #1;
    dsc_rd_ready = 1'b0;
  endtask

  task automatic test_collision_fill;
    @(negedge clock);
    dsc_wr_valid = 1'b1; dsc_wr_idx = 7'd7; dsc_wr_data = PAT_R;
    dsc_inv = 1'b1; dsc_inv_idx = 7'd7;
    @(posedge clock); #1;
    dsc_wr_valid = 1'b0; dsc_inv = 1'b0;
    checks++; if (valid_cnt !== 8'd2) begin errors++; $display("FAIL coll_wr_beats_inv: got %0d expected 2", valid_cnt); end
    @(negedge clock); dsc_inv = 1'b1; dsc_inv_idx = 7'd4;
    @(posedge clock); #1; dsc_inv = 1'b0;
    checks++; if (valid_cnt !== 8'd1) begin errors++; $display("FAIL inv_valid: got %0d expected 1", valid_cnt); end
    @(negedge clock); dsc_inv = 1'b1; dsc_inv_idx = 7'd9;
    @(posedge clock); #1; dsc_inv = 1'b0;
    checks++; if (valid_cnt !== 8'd1) begin errors++; $display("FAIL inv_invalid: got %0d expected 1", valid_cnt); end
    @(negedge clock); dsc_wr_valid = 1'b1; dsc_wr_idx = 7'd7;
    @(posedge clock); #1; dsc_wr_valid = 1'b0;
    checks++; if (valid_cnt !== 8'd1) begin errors++; $display("FAIL rewrite_valid: got %0d expected 1", valid_cnt); end
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      dsc_wr_valid = 1'b1; dsc_wr_idx = ADDR_W'(i); dsc_wr_data = {4{32'(i)}};
    end
    @(posedge clock); #1; dsc_wr_valid = 1'b0;
    checks++; if (valid_cnt !== 8'd128) begin errors++; $display("FAIL fill_valid_cnt: got %0d expected 128", valid_cnt); end
  endtask

  task automatic test_rd_wr_same;
    @(negedge clock);
    dsc_rd_req_valid = 1'b1; dsc_rd_req_idx = 7'd20; dsc_rd_ready = 1'b1;
    dsc_wr_valid = 1'b1; dsc_wr_idx = 7'd20; dsc_wr_data = PAT_N;
    @(posedge clock); #1;
    dsc_rd_req_valid = 1'b0; dsc_wr_valid = 1'b0;
    checks++; if (valid_cnt !== 8'd128) begin errors++; $display("FAIL rdwr_valid_cnt: got %0d expected 128", valid_cnt); end
    @(posedge clock);
    @(posedge clock); #1;
    checks++; if (dsc_rd_data !== {4{32'd20}}) begin errors++; $display("FAIL rdwr_old_data: got %h expected %h", dsc_rd_data, {4{32'd20}}); end
    @(posedge clock);
    @(negedge clock);
    dsc_rd_req_valid = 1'b1; dsc_rd_req_idx = 7'd20;
    @(posedge clock); #1;
    dsc_rd_req_valid = 1'b0;
    checks++; if (valid_cnt !== 8'd127) begin errors++; $display("FAIL rdwr_reread_cnt: got %0d expected 127", valid_cnt); end
    @(posedge clock);
    @(posedge clock); #1;
    checks++; if (dsc_rd_data !== PAT_N || dsc_rd_err !== 1'b0) begin errors++; $display("FAIL rdwr_new_data: got %h err=%b expected %h err=0", dsc_rd_data, dsc_rd_err, PAT_N); end
    @(posedge clock);
    @(negedge clock);
    dsc_rd_req_valid = 1'b1; dsc_rd_req_idx = 7'd30;
    dsc_inv = 1'b1; dsc_inv_idx = 7'd31;
    @(posedge clock); #1;
    dsc_rd_req_valid = 1'b0; dsc_inv = 1'b0;
    checks++; if (valid_cnt !== 8'd125) begin errors++; $display("FAIL rdinv_valid_cnt: got %0d expected 125", valid_cnt); end
    @(posedge clock);
    @(posedge clock); #1;
    checks++; if (dsc_rd_data !== {4{32'd30}}) begin errors++; $display("FAIL rdinv_data: got %h expected %h", dsc_rd_data, {4{32'd30}}); end
    @(posedge clock); #1;
    dsc_rd_ready = 1'b0;
  endtask

  task automatic test_reset_mid_read;
    @(negedge clock);
    dsc_rd_req_valid = 1'b1; dsc_rd_req_idx = 7'd7; dsc_rd_ready = 1'b1;
    @(posedge clock); #1;
    dsc_rd_req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++; if (dsc_rd_valid !== 1'b0 || dsc_rd_err !== 1'b0 || ram_ren !== 1'b0) begin
      errors++; $display("FAIL rst_mid_ctrl: got valid=%b err=%b ren=%b expected all 0", dsc_rd_valid, dsc_rd_err, ram_ren);
    end
    checks++; if (dsc_rd_data !== '0) begin errors++; $display("FAIL rst_mid_data: got %h expected 0", dsc_rd_data); end
    checks++; if (valid_cnt !== 8'd0) begin errors++; $display("FAIL rst_mid_cnt: got %0d expected 0", valid_cnt); end
    repeat (2) @(posedge clock);
    @(negedge clock); reset_n = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    checks++; if (dsc_rd_valid !== 1'b0) begin errors++; $display("FAIL rst_no_response: got %b expected 0", dsc_rd_valid); end
    checks++; if (dsc_rd_req_ready !== 1'b1) begin errors++; $display("FAIL rst_idle: got %b expected 1", dsc_rd_req_ready); end
    dsc_rd_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    ram_s1 = '0; ram_rdata = '0;
    reset_n = 1'b0;
    dsc_wr_valid = 1'b0; dsc_wr_idx = '0; dsc_wr_data = '0;
    dsc_inv = 1'b0; dsc_inv_idx = '0;
    dsc_rd_req_valid = 1'b0; dsc_rd_req_idx = '0; dsc_rd_ready = 1'b0;
    repeat (2) @(posedge clock);
    test_reset;
    test_write;
    test_read_hit;
    test_read_miss;
    test_backpressure;
    test_hazard;
    test_collision_fill;
    test_rd_wr_same;
    test_reset_mid_read;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_dsc_cache_ctrl.md
Name: dma_dsc_cache_ctrl

Overview:
Front-end controller for the DMA descriptor cache RAM (2-stage registered-read SRAM). It accepts descriptor writes and indexed read requests, and keeps a per-entry valid bitmap. It drives the RAM write/read ports and absorbs the RAM read latency. It returns descriptors to the channel engine over a valid/ready response port, with an error flag when the requested entry is empty.

Parameters:
WIDTH, 128, descriptor width in bits (matches cache RAM width)
DEPTH, 128, number of cache entries
ADDR_W, 7, index width; DEPTH = 2**ADDR_W
CLR_ON_RD, 1, 1 = a successful read request clears the entry's valid bit

Ports:
CLOCK  in  1  single clock
RESET_N  in  1  asynchronous active-low reset
DSC_WR_VALID  in  1  write request
DSC_WR_READY  out  1  write accepted when VALID&READY
DSC_WR_IDX  in  ADDR_W  entry to write
DSC_WR_DATA  in  WIDTH  descriptor data
DSC_INV  in  1  invalidate pulse
DSC_INV_IDX  in  ADDR_W  entry to invalidate
DSC_RD_REQ_VALID  in  1  read request
DSC_RD_REQ_READY  out  1  read request accepted when VALID&READY
DSC_RD_REQ_IDX  in  ADDR_W  entry to read
DSC_RD_VALID  out  1  response valid
DSC_RD_READY  in  1  response consumed
DSC_RD_DATA  out  WIDTH  descriptor returned (0 on error)
DSC_RD_ERR  out  1  requested entry was not valid
RAM_WEN  out  1  cache RAM write enable
RAM_WADDR  out  ADDR_W  cache RAM write address
RAM_WDATA  out  WIDTH  cache RAM write data
RAM_REN  out  1  cache RAM read/block enable
RAM_RADDR  out  ADDR_W  cache RAM read address
RAM_RDATA  in  WIDTH  cache RAM read data
VALID_CNT  out  ADDR_W+1  number of valid entries

Behaviour:
- Reset (async, RESET_N=0):
  - valid bitmap all 0; VALID_CNT=0; FSM=IDLE.
  - DSC_RD_VALID=0, DSC_RD_ERR=0, DSC_RD_DATA=0, latched read index=0.
  - Reset mid-read drops the in-flight read; no response is issued.
- Write path (combinational to RAM):
  - RAM_WEN = DSC_WR_VALID & DSC_WR_READY; RAM_WADDR = DSC_WR_IDX; RAM_WDATA = DSC_WR_DATA.
  - An accepted write sets valid[DSC_WR_IDX] at the edge.
- Write hazard: DSC_WR_READY=0 when the FSM is in WAIT or CAPT and DSC_WR_IDX equals the latched read index. Otherwise DSC_WR_READY=1.
- Invalidate: DSC_INV clears valid[DSC_INV_IDX]. It is never stalled.
- Read FSM, states IDLE, WAIT, CAPT, HOLD:
  - DSC_RD_REQ_READY = (FSM==IDLE).
  - On acceptance at edge k, the index is latched and valid[idx] is sampled pre-edge.
  - Hit: RAM_REN=1 and RAM_RADDR=DSC_RD_REQ_IDX, driven combinationally in the accept cycle. IDLE->WAIT at k, WAIT->CAPT at k+1. CAPT->HOLD at k+2, loading RAM_RDATA into DSC_RD_DATA with ERR=0. DSC_RD_VALID=1 from edge k+2.
  - Hit with CLR_ON_RD=1: valid[idx] clears at edge k.
  - Miss: RAM_REN stays 0. IDLE->HOLD at k with DSC_RD_DATA=0, ERR=1, DSC_RD_VALID=1 from edge k.
  - HOLD: DSC_RD_DATA and DSC_RD_ERR stay stable while DSC_RD_READY=0. On DSC_RD_VALID&DSC_RD_READY, go to HOLD->IDLE, clear DSC_RD_VALID and DSC_RD_ERR; DSC_RD_DATA retains its value.
  - A new request is accepted one cycle after the handshake at the earliest. There is one outstanding read at most.
  - RAM_REN=0 outside the hit-accept cycle.
- Simultaneous events on the same index, valid-bit priority (highest first):
  1. write set
  2. invalidate clear
  3. CLR_ON_RD clear
- Same-cycle read accept and write to the same index:
  - The read returns the pre-write RAM contents, or ERR if the entry was invalid pre-edge.
  - The entry ends valid.
- VALID_CNT tracks the popcount of the bitmap exactly, including the next-state result of simultaneous set/clear. Writing an already-valid entry does not increment it; clearing an invalid entry does not decrement it. It never wraps (max DEPTH).

Test Plan:
- Reset then write idx 5 = 128'hA5..A5 -> RAM_WEN=1, RAM_WADDR=5 that cycle; VALID_CNT=1 next cycle.
- Read idx 5, DSC_RD_READY=1, RAM model returns 128'hA5..A5 -> DSC_RD_VALID rises 2 edges after acceptance, DATA=A5..A5, ERR=0; CLR_ON_RD=1 -> VALID_CNT=0.
- Read idx 9 never written -> RAM_REN never asserted, DSC_RD_VALID next cycle with ERR=1, DATA=0.
- Read hit with DSC_RD_READY held 0 for 10 cycles -> DATA/ERR stable, DSC_RD_REQ_READY=0 throughout; response clears the cycle after READY=1.
- Write idx 3 during WAIT of a read to idx 3 -> DSC_WR_READY=0 until CAPT->HOLD; write to idx 4 in the same window is accepted.
- Write and invalidate idx 7 in the same cycle, then fill all 128 entries -> valid[7]=1, VALID_CNT=128; assert RESET_N=0 mid-read -> all outputs 0, VALID_CNT=0 immediately.
